// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-slave AHB-Lite fabric.
// Used by the decoder, the default slave and the bench.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_state_e;

  localparam logic [3:0] DEF_ROM_REGION = 4'h0;
  localparam logic [3:0] DEF_RAM_REGION = 4'h2;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic is_valid(
    input logic [1:0] t
  );
    return (t == HTRANS_NONSEQ) ||
           (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers,
// overriding the ahb_mux hready/hresp while it is active.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic unmapped_i,
  input  logic hready_mux_i,
  input  logic hresp_mux_i,
  output logic hready_o,
  output logic hresp_o,
  output logic err_take_o
);

  def_state_e state_q;
  logic       ovr_q;
  logic       rdy_q;
  logic       ovr_act;
  logic       take_idle;
  logic       take_err2;

  // In IDLE the system hready equals hready_mux.
  assign take_idle = (state_q == DS_IDLE) &&
                     hready_mux_i && unmapped_i;
  assign take_err2 = (state_q == DS_ERR2) &&
                     unmapped_i;

  assign err_take_o = !rst_i &&
                      (take_idle || take_err2);

  assign ovr_act  = ovr_q && !rst_i;
  assign hready_o = ovr_act ? rdy_q : hready_mux_i;
  assign hresp_o  = ovr_act ? 1'b1  : hresp_mux_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DS_IDLE;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        DS_IDLE: begin
          if (take_idle) begin
            state_q <= DS_ERR1;
            ovr_q   <= 1'b1;
            rdy_q   <= 1'b0;
          end else begin
            state_q <= DS_IDLE;
            ovr_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        DS_ERR1: begin
          state_q <= DS_ERR2;
          ovr_q   <= 1'b1;
          rdy_q   <= 1'b1;
        end
        DS_ERR2: begin
          if (take_err2) begin
            state_q <= DS_ERR1;
            ovr_q   <= 1'b1;
            rdy_q   <= 1'b0;
          end else begin
            state_q <= DS_IDLE;
            ovr_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= DS_IDLE;
          ovr_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_decoder_ctrl.sv
// Address decoder, data-phase muxsel register and error status
// for the ROM/RAM AHB-Lite fabric.
module ahb_decoder_ctrl
  import ahb_pkg::*;
#(
  parameter logic [3:0] ROM_REGION = DEF_ROM_REGION,
  parameter logic [3:0] RAM_REGION = DEF_RAM_REGION
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hready_mux,
  input  logic        hresp_mux,
  input  logic        err_clr,
  output logic        hsel_rom,
  output logic        hsel_ram,
  output logic        muxsel,
  output logic        hready,
  output logic        hresp,
  output logic [7:0]  err_count,
  output logic [31:0] err_addr
);

  logic [3:0]  region;
  logic        valid;
  logic        unmapped;
  logic        err_take;
  logic        muxsel_q;
  logic        muxsel_d;
  logic [7:0]  err_count_q;
  logic [7:0]  err_count_d;
  logic [31:0] err_addr_q;
  logic [31:0] err_addr_d;

  assign region   = haddr[31:28];
  assign valid    = is_valid(htrans);
  assign hsel_rom = (region == ROM_REGION);
  assign hsel_ram = (region == RAM_REGION);
  assign unmapped = valid && !hsel_rom && !hsel_ram;

  ahb_default_slave u_def (
    .clk_i        (hclk),
    .rst_i        (hreset),
    .unmapped_i   (unmapped),
    .hready_mux_i (hready_mux),
    .hresp_mux_i  (hresp_mux),
    .hready_o     (hready),
    .hresp_o      (hresp),
    .err_take_o   (err_take)
  );

  // muxsel tracks the address phase that the edge completes.
  always_comb begin
    muxsel_d = muxsel_q;
    if (hready) begin
      muxsel_d = hsel_rom;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (err_take) begin
      err_addr_d  = haddr;
      err_count_d = err_clr ? 8'd1
                            : sat_inc(err_count_q);
    end else if (err_clr) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      muxsel_q    <= 1'b0;
      err_count_q <= 8'd0;
      err_addr_q  <= 32'd0;
    end else begin
      muxsel_q    <= muxsel_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign muxsel    = muxsel_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahb_decoder_ctrl.sv
// Directed bench for ahb_decoder_ctrl: decode, muxsel hold,
// ERROR sequencing, error status and reset behaviour.
module tb_ahb_decoder_ctrl;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready_mux;
  logic        hresp_mux;
  logic        err_clr;
  logic        hsel_rom;
  logic        hsel_ram;
  logic        muxsel;
  logic        hready;
  logic        hresp;
  logic [7:0]  err_count;
  logic [31:0] err_addr;

  int n_chk;
  int n_pass;

  ahb_decoder_ctrl dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .haddr      (haddr),
    .htrans     (htrans),
    .hready_mux (hready_mux),
    .hresp_mux  (hresp_mux),
    .err_clr    (err_clr),
    .hsel_rom   (hsel_rom),
    .hsel_ram   (hsel_ram),
    .muxsel     (muxsel),
    .hready     (hready),
    .hresp      (hresp),
    .err_count  (err_count),
    .err_addr   (err_addr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus(
    input logic [1:0]  t,
    input logic [31:0] a
  );
    htrans = t;
    haddr  = a;
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    hreset     = 1'b1;
    haddr      = 32'd0;
    htrans     = 2'b00;
    hready_mux = 1'b1;
    hresp_mux  = 1'b0;
    err_clr    = 1'b0;

    step();
    step();
    chk("rst_muxsel", muxsel, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_addr", err_addr, 0);
    chk("rst_hready", hready, 1);
    chk("rst_hresp", hresp, 0);
    hreset = 1'b0;

    // ROM read address phase
    bus(2'b10, 32'h0000_0010);
    chk("rom_sel", hsel_rom, 1);
    chk("rom_ram_sel", hsel_ram, 0);
    chk("rom_mux_pre", muxsel, 0);
    step();
    chk("rom_muxsel", muxsel, 1);

    // ROM data phase stalls while RAM address waits
    hready_mux = 1'b0;
    bus(2'b10, 32'h2000_0004);
    chk("ram_sel", hsel_ram, 1);
    chk("ws_hready", hready, 0);
    step();
    chk("ws1_muxsel", muxsel, 1);
    step();
    chk("ws2_muxsel", muxsel, 1);
    hready_mux = 1'b1;
    #1;
    step();
    chk("ws_end_muxsel", muxsel, 0);

    // unmapped NONSEQ
    bus(2'b10, 32'h5000_0000);
    chk("um_sel", {hsel_rom, hsel_ram}, 0);
    chk("um_okay_now", hresp, 0);
    step();
    bus(2'b00, 32'h0);
    chk("e1_hready", hready, 0);
    chk("e1_hresp", hresp, 1);
    chk("e1_cnt", err_count, 1);
    chk("e1_addr", err_addr, 32'h5000_0000);
    step();
    chk("e2_hready", hready, 1);
    chk("e2_hresp", hresp, 1);
    step();
    chk("idle_hready", hready, 1);
    chk("idle_hresp", hresp, 0);

    // IDLE transfer to an unmapped address
    bus(2'b00, 32'h5000_0000);
    step();
    chk("idl_hready", hready, 1);
    chk("idl_hresp", hresp, 0);
    chk("idl_cnt", err_count, 1);

    // back-to-back errors
    bus(2'b10, 32'h5000_0010);
    step();
    bus(2'b00, 32'h0);
    chk("b1_cnt", err_count, 2);
    step();
    bus(2'b11, 32'h6000_0000);
    chk("b2_hresp", hresp, 1);
    step();
    bus(2'b00, 32'h0);
    chk("b3_hready", hready, 0);
    chk("b3_hresp", hresp, 1);
    chk("b3_cnt", err_count, 3);
    chk("b3_addr", err_addr, 32'h6000_0000);
    step();
    err_clr = 1'b1;
    bus(2'b11, 32'h7000_0000);
    step();
    err_clr = 1'b0;
    bus(2'b00, 32'h0);
    chk("clr_inc_cnt", err_count, 1);
    chk("clr_inc_addr", err_addr, 32'h7000_0000);
    step();
    step();
    chk("clr_idle_hresp", hresp, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_only", err_count, 0);

    // saturation: 255 errors back to back, then one more
    bus(2'b10, 32'h8000_0000);
    repeat (509) step();
    chk("sat_255", err_count, 255);
    chk("sat_e1", hready, 0);
    repeat (2) step();
    chk("sat_hold", err_count, 255);
    chk("sat_hold_e1", hready, 0);
    bus(2'b00, 32'h0);
    step();
    step();
    chk("sat_idle_hresp", hresp, 0);

    // reset during ERR1
    bus(2'b10, 32'h0000_0020);
    step();
    chk("pre_rst_mux", muxsel, 1);
    bus(2'b10, 32'h9000_0000);
    step();
    chk("pre_rst_e1", hready, 0);
    hreset    = 1'b1;
    hresp_mux = 1'b0;
    bus(2'b00, 32'h0);
    chk("rst_e1_hready", hready, 1);
    chk("rst_e1_hresp", hresp, 0);
    step();
    hreset    = 1'b0;
    hresp_mux = 1'b1;
    #1;
    chk("post_rst_hresp", hresp, 1);
    chk("post_rst_hready", hready, 1);
    chk("post_rst_mux", muxsel, 0);
    chk("post_rst_cnt", err_count, 0);
    hresp_mux = 1'b0;
    #1;
    chk("post_rst_okay", hresp, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
